// File: rtl/bank_cmd_gate_pkg.sv
// Shared types and widths for the per-bank command gate.
// Holds the command/recode encodings, FSM state type and counter slice widths.
package bank_cmd_gate_pkg;

   localparam int unsigned CMD_W  = 3;
   localparam int unsigned TP_W   = 5;
   localparam int unsigned TRAS_W = 6;
   localparam int unsigned CODE_W = 3;

   typedef enum logic [CMD_W-1:0] {
      CMD_NOP = 3'd0,
      CMD_ACT = 3'd1,
      CMD_RD  = 3'd2,
      CMD_WR  = 3'd3,
      CMD_PRE = 3'd4
   } cmd_t;

   typedef enum logic [CODE_W-1:0] {
      RC_NONE       = 3'd0,
      RC_WR_TO_PRE  = 3'd1,
      RC_PRE_TO_ACT = 3'd2,
      RC_ACT_TO_RW  = 3'd3,
      RC_RD_TO_PRE  = 3'd4
   } recode_state_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_HOLD  = 2'd1,
      ST_ISSUE = 2'd2
   } gate_state_t;

   // Bank has no open row (never used, or last command was a precharge).
   function automatic logic code_closed(input logic [CODE_W-1:0] c);
      return (c == RC_NONE) || (c == RC_PRE_TO_ACT);
   endfunction

   // Bank is open and a column access has already happened.
   function automatic logic code_after_col(input logic [CODE_W-1:0] c);
      return (c == RC_WR_TO_PRE) || (c == RC_RD_TO_PRE);
   endfunction

endpackage

// File: rtl/bank_cmd_gate_legal_chk.sv
// Combinational legality check of one command against one bank's timing state.
// Exactly one of legal/illegal is set, or neither when the command must keep waiting.
module bank_cmd_gate_legal_chk
   import bank_cmd_gate_pkg::*;
(
   input  cmd_t              cmd,
   input  logic [CODE_W-1:0] c,
   input  logic [TP_W-1:0]   t,
   input  logic [TRAS_W-1:0] r,
   output logic              legal,
   output logic              illegal
);

   always_comb begin
      legal   = 1'b0;
      illegal = 1'b0;
      case (cmd)
         CMD_ACT: begin
            if (code_closed(c)) legal = (t == '0) && (r == '0);
            else                illegal = 1'b1;
         end
         CMD_RD, CMD_WR: begin
            if (c == RC_ACT_TO_RW)      legal = (t == '0);
            else if (code_after_col(c)) legal = 1'b1;
            else                        illegal = 1'b1;
         end
         CMD_PRE: begin
            // Precharging an already closed bank is harmless and goes straight out.
            if (code_closed(c))         legal = 1'b1;
            else if (c == RC_ACT_TO_RW) legal = (r == '0);
            else if (code_after_col(c)) legal = (t == '0) && (r == '0);
            else                        illegal = 1'b1;
         end
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/bank_cmd_gate.sv
// Holds one scheduler request until the target bank's live timing counters allow it, then issues it.
// Optional watchdog on HOLD time: define CMD_GATE_WATCHDOG_EN (adds MAX_WAIT parameter).
module bank_cmd_gate
   import bank_cmd_gate_pkg::*;
#(
   parameter  int unsigned NUM_BANKS = 8,
   parameter  int unsigned ADDR_W    = 16,
`ifdef CMD_GATE_WATCHDOG_EN
   parameter  int unsigned MAX_WAIT  = 63,
`endif
   localparam int unsigned BA_W      = $clog2(NUM_BANKS)
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        req_valid,
   output logic                        req_ready,
   input  logic [CMD_W-1:0]            req_cmd,
   input  logic [BA_W-1:0]             req_bank,
   input  logic [ADDR_W-1:0]           req_addr,
   input  logic [NUM_BANKS*TP_W-1:0]   tp_cnt_all,
   input  logic [NUM_BANKS*TRAS_W-1:0] tras_cnt_all,
   input  logic [NUM_BANKS*CODE_W-1:0] code_all,
   output logic                        issue_valid,
   output logic [CMD_W-1:0]            issue_cmd,
   output logic [BA_W-1:0]             issue_bank,
   output logic [ADDR_W-1:0]           issue_addr,
   output logic                        seq_err,
   output logic                        wait_timeout
);

   gate_state_t       state_q, state_d;
   cmd_t              hold_cmd_q, hold_cmd_d;
   logic [BA_W-1:0]   hold_bank_q, hold_bank_d;
   logic [ADDR_W-1:0] hold_addr_q, hold_addr_d;
   logic              req_ready_q, req_ready_d;
   logic              issue_valid_q, issue_valid_d;
   cmd_t              issue_cmd_q, issue_cmd_d;
   logic [BA_W-1:0]   issue_bank_q, issue_bank_d;
   logic [ADDR_W-1:0] issue_addr_q, issue_addr_d;
   logic              seq_err_q, seq_err_d;

   logic [TP_W-1:0]   tp_arr   [NUM_BANKS];
   logic [TRAS_W-1:0] tras_arr [NUM_BANKS];
   logic [CODE_W-1:0] code_arr [NUM_BANKS];
   logic              legal_c, illegal_c;

   for (genvar gb = 0; gb < NUM_BANKS; gb++) begin : g_slice
      assign tp_arr[gb]   = tp_cnt_all[gb*TP_W +: TP_W];
      assign tras_arr[gb] = tras_cnt_all[gb*TRAS_W +: TRAS_W];
      assign code_arr[gb] = code_all[gb*CODE_W +: CODE_W];
   end

   // Counters are read live from the held bank every HOLD cycle.
   bank_cmd_gate_legal_chk u_chk (
      .cmd     (hold_cmd_q),
      .c       (code_arr[hold_bank_q]),
      .t       (tp_arr[hold_bank_q]),
      .r       (tras_arr[hold_bank_q]),
      .legal   (legal_c),
      .illegal (illegal_c)
   );

`ifdef CMD_GATE_WATCHDOG_EN
   localparam int unsigned WAIT_W = 6;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);
   logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic              timeout_q, timeout_d;
`endif

   always_comb begin
      state_d       = state_q;
      hold_cmd_d    = hold_cmd_q;
      hold_bank_d   = hold_bank_q;
      hold_addr_d   = hold_addr_q;
      issue_valid_d = 1'b0;
      issue_cmd_d   = CMD_NOP;
      issue_bank_d  = issue_bank_q;
      issue_addr_d  = issue_addr_q;
      seq_err_d     = 1'b0;
`ifdef CMD_GATE_WATCHDOG_EN
      wait_cnt_d    = wait_cnt_q;
      timeout_d     = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            if (req_valid && req_ready_q && (req_cmd != CMD_NOP)) begin
               hold_cmd_d  = cmd_t'(req_cmd);
               hold_bank_d = req_bank;
               hold_addr_d = req_addr;
               state_d     = ST_HOLD;
`ifdef CMD_GATE_WATCHDOG_EN
               wait_cnt_d  = '0;
`endif
            end
         end
         ST_HOLD: begin
            if (illegal_c) begin
               seq_err_d = 1'b1;
               state_d   = ST_IDLE;
            end else if (legal_c) begin
               issue_valid_d = 1'b1;
               issue_cmd_d   = hold_cmd_q;
               issue_bank_d  = hold_bank_q;
               issue_addr_d  = hold_addr_q;
               state_d       = ST_ISSUE;
            end
`ifdef CMD_GATE_WATCHDOG_EN
            else if (wait_cnt_q == WAIT_LAST) begin
               timeout_d = 1'b1;
               state_d   = ST_IDLE;
            end else begin
               wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            end
`endif
         end
         ST_ISSUE: state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
      req_ready_d = (state_d == ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         hold_cmd_q    <= CMD_NOP;
         hold_bank_q   <= '0;
         hold_addr_q   <= '0;
         req_ready_q   <= 1'b1;
         issue_valid_q <= 1'b0;
         issue_cmd_q   <= CMD_NOP;
         issue_bank_q  <= '0;
         issue_addr_q  <= '0;
         seq_err_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         hold_cmd_q    <= hold_cmd_d;
         hold_bank_q   <= hold_bank_d;
         hold_addr_q   <= hold_addr_d;
         req_ready_q   <= req_ready_d;
         issue_valid_q <= issue_valid_d;
         issue_cmd_q   <= issue_cmd_d;
         issue_bank_q  <= issue_bank_d;
         issue_addr_q  <= issue_addr_d;
         seq_err_q     <= seq_err_d;
      end
   end

`ifdef CMD_GATE_WATCHDOG_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt_q <= '0;
         timeout_q  <= 1'b0;
      end else begin
         wait_cnt_q <= wait_cnt_d;
         timeout_q  <= timeout_d;
      end
   end
   assign wait_timeout = timeout_q;
`else
   assign wait_timeout = 1'b0;
`endif

   assign req_ready   = req_ready_q;
   assign issue_valid = issue_valid_q;
   assign issue_cmd   = issue_cmd_q;
   assign issue_bank  = issue_bank_q;
   assign issue_addr  = issue_addr_q;
   assign seq_err     = seq_err_q;

endmodule

// File: tb/tb_bank_cmd_gate.sv
// Bench for bank_cmd_gate: directed scenarios plus randomized requests against a rule-level model.
// Works with or without CMD_GATE_WATCHDOG_EN (watchdog limit overridden to 4 cycles).
module tb_bank_cmd_gate;

   localparam int NB = 8;
   localparam int AW = 16;
   localparam int TB_MAX_WAIT = 4;
   localparam int WT = 0, GO = 1, ER = 2, TO = 3;
   localparam int C_ACT = 1, C_RD = 2, C_WR = 3, C_PRE = 4;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            req_valid = 1'b0;
   logic            req_ready;
   logic [2:0]      req_cmd = 3'd0;
   logic [2:0]      req_bank = 3'd0;
   logic [AW-1:0]   req_addr = '0;
   logic [NB*5-1:0] tp_cnt_all = '0;
   logic [NB*6-1:0] tras_cnt_all = '0;
   logic [NB*3-1:0] code_all = '0;
   logic            issue_valid;
   logic [2:0]      issue_cmd;
   logic [2:0]      issue_bank;
   logic [AW-1:0]   issue_addr;
   logic            seq_err;
   logic            wait_timeout;

   int tp [NB];
   int tr [NB];
   int cd [NB];
   int n_vec = 0;
   int n_err = 0;

   bank_cmd_gate #(
      .NUM_BANKS (NB),
`ifdef CMD_GATE_WATCHDOG_EN
      .MAX_WAIT  (TB_MAX_WAIT),
`endif
      .ADDR_W    (AW)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_cmd      (req_cmd),
      .req_bank     (req_bank),
      .req_addr     (req_addr),
      .tp_cnt_all   (tp_cnt_all),
      .tras_cnt_all (tras_cnt_all),
      .code_all     (code_all),
      .issue_valid  (issue_valid),
      .issue_cmd    (issue_cmd),
      .issue_bank   (issue_bank),
      .issue_addr   (issue_addr),
      .seq_err      (seq_err),
      .wait_timeout (wait_timeout)
   );

   always #5 clk = ~clk;

   // Outcome of one HOLD cycle, straight from the command-sequence rules.
   function automatic int model(input int cmd, input int c, input int t, input int r);
      bit open_row  = (c == 1) || (c == 3) || (c == 4);
      bit closed    = (c == 0) || (c == 2);
      bit after_col = (c == 1) || (c == 4);
      if (!open_row && !closed) return ER;
      if (cmd == C_ACT) return open_row ? ER : ((t == 0 && r == 0) ? GO : WT);
      if (cmd == C_RD || cmd == C_WR) begin
         if (closed) return ER;
         if (after_col) return GO;
         return (t == 0) ? GO : WT;
      end
      if (closed) return GO;
      if (c == 3) return (r == 0) ? GO : WT;
      return (t == 0 && r == 0) ? GO : WT;
   endfunction

   task automatic apply_counters();
      for (int b = 0; b < NB; b++) begin
         tp_cnt_all[b*5 +: 5]   = 5'(tp[b]);
         tras_cnt_all[b*6 +: 6] = 6'(tr[b]);
         code_all[b*3 +: 3]     = 3'(cd[b]);
      end
   endtask

   task automatic clear_banks();
      for (int b = 0; b < NB; b++) begin
         tp[b] = 0; tr[b] = 0; cd[b] = 0;
      end
      apply_counters();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      req_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // One request: accept, then each HOLD cycle predict and compare; target counters decay 1/cycle.
   task automatic do_req(input int cmd, input int bank, input int addr, input bit scramble);
      int pred;
      int k;
      logic [3:0] exp_flags;
      @(negedge clk);
      req_valid = 1'b1;
      req_cmd   = 3'(cmd);
      req_bank  = 3'(bank);
      req_addr  = AW'(addr);
      @(posedge clk); #1;
      n_vec++;
      if (req_ready !== 1'b0) begin
         n_err++;
         $display("FAIL accept_ready: got %b expected 0", req_ready);
      end
      @(negedge clk);
      req_valid = 1'b0;
      pred = WT;
      for (k = 0; k < 200; k++) begin
         pred = model(cmd, cd[bank], tp[bank], tr[bank]);
`ifdef CMD_GATE_WATCHDOG_EN
         if (pred == WT && k == TB_MAX_WAIT - 1) pred = TO;
`endif
         @(posedge clk); #1;
         case (pred)
            GO:      exp_flags = 4'b1000;
            ER:      exp_flags = 4'b0101;
            TO:      exp_flags = 4'b0011;
            default: exp_flags = 4'b0000;
         endcase
         n_vec++;
         if ({issue_valid, seq_err, wait_timeout, req_ready} !== exp_flags) begin
            n_err++;
            $display("FAIL hold_flags cmd=%0d bank=%0d cyc=%0d: got iv/err/to/rdy=%b expected %b",
                     cmd, bank, k, {issue_valid, seq_err, wait_timeout, req_ready}, exp_flags);
         end
         if (pred == GO) begin
            n_vec++;
            if ({issue_cmd, issue_bank, issue_addr} !== {3'(cmd), 3'(bank), AW'(addr)}) begin
               n_err++;
               $display("FAIL issue_fields: got cmd=%0d bank=%0d addr=%h expected cmd=%0d bank=%0d addr=%h",
                        issue_cmd, issue_bank, issue_addr, cmd, bank, addr);
            end
         end
         if (pred != WT) break;
         @(negedge clk);
         if (tp[bank] > 0) tp[bank]--;
         if (tr[bank] > 0) tr[bank]--;
         if (scramble) begin
            for (int b = 0; b < NB; b++)
               if (b != bank) begin
                  tp[b] = $urandom_range(0, 31); tr[b] = $urandom_range(0, 63); cd[b] = $urandom_range(0, 7);
               end
         end
         apply_counters();
      end
      if (k == 200) begin
         n_vec++; n_err++;
         $display("FAIL hold_bound: got no resolution in 200 cycles expected issue or error");
      end
      @(posedge clk); #1;
      n_vec++;
      if ({issue_valid, seq_err, wait_timeout, req_ready, issue_cmd} !== {4'b0001, 3'd0}) begin
         n_err++;
         $display("FAIL post_flags: got iv/err/to/rdy=%b cmd=%0d expected 0001 cmd=0",
                  {issue_valid, seq_err, wait_timeout, req_ready}, issue_cmd);
      end
      if (pred == GO) begin
         n_vec++;
         if ({issue_bank, issue_addr} !== {3'(bank), AW'(addr)}) begin
            n_err++;
            $display("FAIL post_hold_fields: got bank=%0d addr=%h expected bank=%0d addr=%h",
                     issue_bank, issue_addr, bank, addr);
         end
      end
   endtask

   task automatic test_reset();
      #1;
      n_vec++;
      if ({req_ready, issue_valid, issue_cmd, issue_bank, issue_addr, seq_err, wait_timeout} !==
          {1'b1, 1'b0, 3'd0, 3'd0, 16'd0, 1'b0, 1'b0}) begin
         n_err++;
         $display("FAIL reset_state: got rdy=%b iv=%b cmd=%0d bank=%0d addr=%h err=%b to=%b expected 1 0 0 0 0000 0 0",
                  req_ready, issue_valid, issue_cmd, issue_bank, issue_addr, seq_err, wait_timeout);
      end
   endtask

   task automatic test_directed();
      clear_banks();
      do_req(C_ACT, 2, 16'h1234, 1'b0);                  // immediate ACT
      clear_banks(); cd[1] = 3; tp[1] = 3; apply_counters();
      do_req(C_RD, 1, 16'h0040, 1'b0);                   // tRCD wait
      clear_banks(); cd[0] = 1; tr[0] = 5; apply_counters();
      do_req(C_PRE, 0, 16'h0000, 1'b0);                  // tRAS gating
      clear_banks(); cd[3] = 2; apply_counters();
      do_req(C_WR, 3, 16'h0abc, 1'b0);                   // no open row
      clear_banks(); cd[6] = 4; apply_counters();
      do_req(C_ACT, 6, 16'h0777, 1'b0);                  // ACT to open bank
      clear_banks(); cd[7] = 0; tp[7] = 9; tr[7] = 9; apply_counters();
      do_req(C_PRE, 7, 16'h0001, 1'b0);                  // idempotent precharge
      clear_banks(); cd[5] = 6; apply_counters();
      do_req(C_PRE, 5, 16'h0002, 1'b0);                  // undefined code
   endtask

   task automatic test_nop();
      @(negedge clk);
      req_valid = 1'b1; req_cmd = 3'd0; req_bank = 3'd4; req_addr = 16'hffff;
      @(posedge clk); #1;
      @(negedge clk);
      req_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         n_vec++;
         if ({issue_valid, seq_err, req_ready, issue_cmd} !== {3'b001, 3'd0}) begin
            n_err++;
            $display("FAIL nop_discard: got iv/err/rdy=%b cmd=%0d expected 001 cmd=0",
                     {issue_valid, seq_err, req_ready}, issue_cmd);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [1:0] exp [6];
      exp[0] = 2'b00; exp[1] = 2'b10; exp[2] = 2'b01; exp[3] = 2'b00; exp[4] = 2'b10; exp[5] = 2'b01;
      clear_banks();
      @(negedge clk);
      req_valid = 1'b1; req_cmd = 3'(C_ACT); req_bank = 3'd2; req_addr = 16'h0055;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         n_vec++;
         if ({issue_valid, req_ready} !== exp[i]) begin
            n_err++;
            $display("FAIL b2b_edge%0d: got iv/rdy=%b expected %b", i, {issue_valid, req_ready}, exp[i]);
         end
         if (i == 4) begin
            @(negedge clk);
            req_valid = 1'b0;
         end
      end
   endtask

   task automatic test_reset_mid_hold();
      clear_banks(); tp[5] = 7; apply_counters();
      @(negedge clk);
      req_valid = 1'b1; req_cmd = 3'(C_ACT); req_bank = 3'd5; req_addr = 16'h5555;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_vec++;
      if ({req_ready, issue_valid, issue_cmd, seq_err, wait_timeout} !== {2'b10, 3'd0, 2'b00}) begin
         n_err++;
         $display("FAIL async_reset: got rdy=%b iv=%b cmd=%0d err=%b to=%b expected 1 0 0 0 0",
                  req_ready, issue_valid, issue_cmd, seq_err, wait_timeout);
      end
      tp[5] = 0; apply_counters();
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         n_vec++;
         if ({issue_valid, req_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL post_reset_drop%0d: got iv/rdy=%b expected 01", i, {issue_valid, req_ready});
         end
      end
   endtask

   task automatic test_watchdog();
      logic exp_to;
      clear_banks(); tp[4] = 7; apply_counters();
      @(negedge clk);
      req_valid = 1'b1; req_cmd = 3'(C_ACT); req_bank = 3'd4; req_addr = 16'h0404;
      @(posedge clk); #1;
      @(negedge clk);
      req_valid = 1'b0;
`ifdef CMD_GATE_WATCHDOG_EN
      for (int i = 1; i <= TB_MAX_WAIT + 1; i++) begin
         @(posedge clk); #1;
         exp_to = (i == TB_MAX_WAIT);
         n_vec++;
         if ({wait_timeout, issue_valid, req_ready} !== {exp_to, 1'b0, (i >= TB_MAX_WAIT)}) begin
            n_err++;
            $display("FAIL watchdog_cyc%0d: got to/iv/rdy=%b expected %b", i,
                     {wait_timeout, issue_valid, req_ready}, {exp_to, 1'b0, (i >= TB_MAX_WAIT)});
         end
      end
`else
      exp_to = 1'b0;
      for (int i = 0; i < 80; i++) begin
         @(posedge clk); #1;
         if (i % 20 == 19) begin
            n_vec++;
            if ({wait_timeout, issue_valid, req_ready} !== {exp_to, 2'b00}) begin
               n_err++;
               $display("FAIL stuck_hold_cyc%0d: got to/iv/rdy=%b expected 000", i,
                        {wait_timeout, issue_valid, req_ready});
            end
         end
      end
      do_reset();
`endif
   endtask

   task automatic test_random();
      int cmd, bank;
      for (int n = 0; n < 40; n++) begin
         for (int b = 0; b < NB; b++) begin
            tp[b] = $urandom_range(0, 31); tr[b] = $urandom_range(0, 63); cd[b] = $urandom_range(0, 7);
         end
         bank = $urandom_range(0, NB - 1);
         cmd  = $urandom_range(C_ACT, C_PRE);
         cd[bank] = $urandom_range(0, 5);
         tp[bank] = $urandom_range(0, 6);
         tr[bank] = $urandom_range(0, 6);
         apply_counters();
         do_req(cmd, bank, int'($urandom_range(0, 65535)), 1'b1);
      end
   endtask

   initial begin
      clear_banks();
      repeat (2) @(negedge clk);
      test_reset();
      rst_n = 1'b1;
      test_directed();
      test_nop();
      test_back_to_back();
      test_reset_mid_hold();
      test_watchdog();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
